// File: rtl/fixed_point_pkg.sv
// fixed_point_pkg
// Shared constants and types for the sign-magnitude Q-format divider.
//   N_DEF / Q_DEF : default word width and fractional bit count
//   ONE           : magnitude of 1.0 at the default format (1 << Q_DEF)
//   MAX_MAG       : largest representable magnitude at the default format
//   state_t       : divider control states
package fixed_point_pkg;

    localparam int N_DEF = 32;
    localparam int Q_DEF = 16;

    localparam logic [N_DEF-2:0] ONE     = (N_DEF-1)'(1) << Q_DEF;
    localparam logic [N_DEF-2:0] MAX_MAG = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// div_step
// One combinational restoring-division step.
//   rem     : partial remainder going in (always < dsr for a nonzero divisor)
//   din     : next dividend bit shifted into the remainder
//   dsr     : divisor magnitude
//   rem_nxt : partial remainder after the trial subtraction
//   q       : retired quotient bit
module div_step #(
    parameter int W = 31
) (
    input  logic [W-1:0] rem,
    input  logic         din,
    input  logic [W-1:0] dsr,
    output logic [W-1:0] rem_nxt,
    output logic         q
);

    logic [W:0] shifted;
    logic [W:0] diff;

    always_comb begin
        shifted = {rem, din};
        diff    = shifted - {1'b0, dsr};
        q       = (shifted >= {1'b0, dsr});
        // The kept value is always below the divisor, so W bits suffice; a
        // zero divisor is flagged by the caller and its remainder is don't-care.
        rem_nxt = q ? W'(diff) : W'(shifted);
    end

endmodule

// File: rtl/seq_divider.sv
// seq_divider
// Sequential restoring divider for sign-magnitude Q-format words. Accepts an
// operand set in IDLE, runs one quotient bit per clock in CALC (N-1+Q clocks),
// then presents the result in DONE until the consumer takes it.
//   clk, rst_n          : clock and asynchronous active-low reset
//   in_valid / in_ready : operand handshake (ready only in IDLE)
//   op                  : 0 = a/b, 1 = 1/b (a ignored)
//   a, b                : dividend and divisor, sign-magnitude Q format
//   out_valid/out_ready : result handshake (valid only in DONE)
//   c                   : quotient, sign-magnitude Q format
//   dz                  : divide-by-zero flag, qualified by out_valid
//   ovf                 : saturation flag, qualified by out_valid
module seq_divider
    import fixed_point_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int Q = Q_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         dz,
    output logic         ovf
);

    localparam int MAG_W = N - 1;
    localparam int ITERS = N - 1 + Q;
    localparam int QW    = ITERS - 1;
    localparam int CNT_W = $clog2(N + Q);

    localparam logic [MAG_W-1:0] ONE_MAG = MAG_W'(1) << Q;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [ITERS-1:0]   dvd;     // dividend bits still to be consumed, MSB first
    logic [MAG_W-1:0]   dsr;
    logic [MAG_W-1:0]   rem;
    logic [QW-1:0]      quo;     // quotient bits retired before the final step
    logic               sgn;

    logic [MAG_W-1:0]   rem_nxt;
    logic               q_bit;

    logic               a_neg;
    logic               b_neg;

    // -0 carries no sign; this also yields the dz sign rule since |b| == 0.
    assign a_neg = a[N-1] && (a[N-2:0] != '0);
    assign b_neg = b[N-1] && (b[N-2:0] != '0);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    div_step #(.W(MAG_W)) u_step (
        .rem     (rem),
        .din     (dvd[ITERS-1]),
        .dsr     (dsr),
        .rem_nxt (rem_nxt),
        .q       (q_bit)
    );

    // Packs {dz, ovf, c} from the full raw quotient. Saturation and
    // divide-by-zero both force the all-ones magnitude; a zero magnitude
    // always drops the sign.
    function automatic logic [N+1:0] finish_result(
        input logic             s,
        input logic [ITERS-1:0] raw,
        input logic             zero_div
    );
        logic             of;
        logic [MAG_W-1:0] mag;
        of  = !zero_div && (raw[ITERS-1:MAG_W] != '0);
        mag = (zero_div || of) ? '1 : raw[MAG_W-1:0];
        return {zero_div, of, (mag == '0) ? 1'b0 : s, mag};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            dvd   <= '0;
            dsr   <= '0;
            rem   <= '0;
            quo   <= '0;
            sgn   <= 1'b0;
            c     <= '0;
            dz    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd   <= {(op ? ONE_MAG : a[N-2:0]), {Q{1'b0}}};
                        dsr   <= b[N-2:0];
                        sgn   <= op ? b_neg : (a_neg ^ b_neg);
                        rem   <= '0;
                        quo   <= '0;
                        cnt   <= CNT_W'(ITERS);
                        state <= CALC;
                    end
                end
                CALC: begin
                    dvd <= dvd << 1;
                    rem <= rem_nxt;
                    quo <= QW'({quo, q_bit});
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        {dz, ovf, c} <= finish_result(sgn, {quo, q_bit}, (dsr == '0));
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter N, default 32, SHALL set the total word width: sign-magnitude, bit N-1 = sign, bits N-2:0 = magnitude.
REQ-002 Parameter Q, default 16, SHALL set the number of fractional magnitude bits; legal range 1..N-2.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port in_valid, input, 1 bit: the operand set is valid.
REQ-006 Port in_ready, output, 1 bit: the block can accept operands.
REQ-007 Port op, input, 1 bit: 0 = divide a/b; 1 = reciprocal 1/b, with a ignored.
REQ-008 Ports a and b, input, N bits each: dividend and divisor in sign-magnitude Q format.
REQ-009 Port out_valid, output, 1 bit: the result is valid.
REQ-010 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 Port c, output, N bits: the quotient in sign-magnitude Q format.
REQ-012 Port dz, output, 1 bit: divide-by-zero flag, qualified by out_valid.
REQ-013 Port ovf, output, 1 bit: saturation flag, qualified by out_valid.

Function
REQ-014 The state machine SHALL have exactly three states, IDLE, CALC and DONE; in_ready = (state==IDLE) and out_valid = (state==DONE).
REQ-015 IDLE with in_valid=1 SHALL, on that edge:
  - latch |a| (or 1<<Q when op=1) as the dividend, |b| as the divisor, and sign = sign(a) XOR sign(b) (sign(b) alone when op=1);
  - clear the remainder and set the iteration counter to ITERS = N-1+Q;
  - enter CALC.
REQ-016 Each CALC edge SHALL perform one restoring-division step over the (N-1+Q)-bit dividend {|a|, Q zeros}, retiring one quotient bit, MSB first, and decrementing the counter.
REQ-017 The CALC edge that retires the last quotient bit SHALL register c, dz and ovf and enter DONE, so out_valid rises exactly ITERS edges after the acceptance edge (47 edges for the defaults), independent of operand values.
REQ-018 ovf SHALL be 1 when any of the upper Q bits of the (N-1+Q)-bit raw quotient is set; c then SHALL be {sign, all-ones magnitude}.
REQ-019 When |b| == 0, dz SHALL be 1 and ovf 0, c SHALL be {sign(a), all-ones magnitude} (sign 0 when op=1), and the latency SHALL be unchanged.
REQ-020 A zero result magnitude SHALL always be output with sign 0; negative zero is never produced.
REQ-021 In DONE, c, dz and ovf SHALL hold stable until out_ready=1.
REQ-022 The edge where out_valid and out_ready are both 1 SHALL return the block to IDLE; there is no same-edge re-accept, so the minimum issue interval is ITERS+2 edges.
REQ-023 Inputs a, b, op and in_valid SHALL be ignored outside IDLE.
REQ-024 Operands of -0 (sign 1, magnitude 0) SHALL be treated as 0.

Reset
REQ-025 rst_n=0 SHALL, asynchronously and at any state including mid-CALC, force:
  - state IDLE, in_ready 1, out_valid 0;
  - c 0, dz 0, ovf 0;
  - counter, remainder and quotient registers 0.
REQ-026 Any in-flight operation SHALL be discarded on reset and no result for it SHALL ever appear.
REQ-027 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-028 Package fixed_point_pkg SHALL hold:
  - default N and Q;
  - constant ONE (1<<Q);
  - the sign-magnitude MAX magnitude constant;
  - the state enum {IDLE, CALC, DONE}.
REQ-029 One sub-module, div_step, SHALL implement a single combinational restoring step: inputs remainder, next dividend bit and divisor; outputs new remainder and quotient bit. The top SHALL contain the FSM, counter and registers.
REQ-030 The iteration counter width SHALL be $clog2(N+Q).

Verification
REQ-031 The bench SHALL cover: 6.0/2.0, a=0x00060000, b=0x00020000, op=0 -> c=0x00030000, dz=0, ovf=0, out_valid exactly 47 edges after acceptance.
REQ-032 The bench SHALL cover: -1.0/4.0, a=0x80010000, b=0x00040000 -> c=0x80004000; reciprocal of 0.5, op=1, b=0x00008000 -> c=0x00020000.
REQ-033 The bench SHALL cover: 5.0/0, a=0x00050000, b=0x00000000 -> c=0x7FFFFFFF, dz=1, ovf=0; -5.0/0 -> c=0xFFFFFFFF, dz=1.
REQ-034 The bench SHALL cover: 16384.0/0.25, a=0x40000000, b=0x00004000 -> c=0x7FFFFFFF, ovf=1, dz=0; 0/-3.0 -> c=0x00000000.
REQ-035 The bench SHALL cover: out_ready held low 10 edges in DONE -> c stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE on the next edge.
REQ-036 The bench SHALL cover: rst_n pulsed low at CALC edge 20 -> out_valid stays 0, in_ready=1 immediately, and the next operation returns the correct result with full latency.
